// File: rtl/sp_sram_param.sv
// Single-port SRAM with registered read, out-of-range flagging and a power-up clear sweep.
// Define SPSRAM_INIT_CLEAR_EN to zero every word after reset; without it the block is ready one cycle after reset.
module sp_sram_param #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 4
) (
  input  logic              iClk12M,
  input  logic              iRst,
  input  logic              iCsnRam,
  input  logic              iWrnRam,
  input  logic [ADDR_W-1:0] iAddrRam,
  input  logic [DATA_W-1:0] iWtDtRam,
  output logic [DATA_W-1:0] oRdDtRam,
  output logic              oRdVld,
  output logic              oAddrErr,
  output logic              oInitDone
);

  // state | meaning
  // Init  | clearing memory (or waiting one cycle), accesses ignored
  // Ready | serving reads and writes until reset
  typedef enum logic {Init, Ready} state_t;

  // One extra bit so DEPTH == 2**ADDR_W compares correctly.
  localparam logic [ADDR_W:0] DepthL = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              inRange;
  logic              access;

  assign inRange = ({1'b0, iAddrRam} < DepthL);
  assign access  = (state == Ready) && !iCsnRam;

`ifdef SPSRAM_INIT_CLEAR_EN
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH-1);
  logic [ADDR_W-1:0] clrCnt;
`endif

  // Memory array carries no reset; the sweep is the only way it gets cleared.
  always_ff @(posedge iClk12M) begin
`ifdef SPSRAM_INIT_CLEAR_EN
    if (!iRst && state == Init)
      mem[clrCnt] <= '0;
    else
`endif
    if (access && !iWrnRam && inRange)
      mem[iAddrRam] <= iWtDtRam;
  end

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      state     <= Init;
      oRdDtRam  <= '0;
      oRdVld    <= 1'b0;
      oAddrErr  <= 1'b0;
      oInitDone <= 1'b0;
`ifdef SPSRAM_INIT_CLEAR_EN
      clrCnt    <= '0;
`endif
    end else begin
      oRdVld   <= 1'b0;
      oAddrErr <= 1'b0;
      case (state)
        Init: begin
`ifdef SPSRAM_INIT_CLEAR_EN
          if (clrCnt == LastAddr) begin
            state     <= Ready;
            oInitDone <= 1'b1;
          end else begin
            clrCnt <= clrCnt + 1'b1;
          end
`else
          state     <= Ready;
          oInitDone <= 1'b1;
`endif
        end
        Ready: begin
          if (!iCsnRam) begin
            if (!inRange) begin
              oAddrErr <= 1'b1;
              if (iWrnRam) begin
                oRdDtRam <= '0;
                oRdVld   <= 1'b1;
              end
            end else if (iWrnRam) begin
              oRdDtRam <= mem[iAddrRam];
              oRdVld   <= 1'b1;
            end
          end
        end
        default: state <= Init;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_sram_param.sv
// Bench for sp_sram_param: default instance driven from a vector table, plus a 24x20 instance.
module tb_sp_sram_param;

  logic        Clk12M = 1'b0;
  logic        rst    = 1'b1;

  logic        aCsn = 1'b1, aWrn = 1'b1;
  logic [3:0]  aAddr = '0;
  logic [15:0] aWd   = '0;
  logic [15:0] aRd;
  logic        aVld, aErr, aDone;

  logic        bCsn = 1'b1, bWrn = 1'b1;
  logic [4:0]  bAddr = '0;
  logic [23:0] bWd   = '0;
  logic [23:0] bRd;
  logic        bVld, bErr, bDone;

  always #41 Clk12M = ~Clk12M;

  sp_sram_param dutA (
    .iClk12M(Clk12M), .iRst(rst), .iCsnRam(aCsn), .iWrnRam(aWrn),
    .iAddrRam(aAddr), .iWtDtRam(aWd), .oRdDtRam(aRd), .oRdVld(aVld),
    .oAddrErr(aErr), .oInitDone(aDone)
  );

  sp_sram_param #(.DATA_W(24), .DEPTH(20), .ADDR_W(5)) dutB (
    .iClk12M(Clk12M), .iRst(rst), .iCsnRam(bCsn), .iWrnRam(bWrn),
    .iAddrRam(bAddr), .iWtDtRam(bWd), .oRdDtRam(bRd), .oRdVld(bVld),
    .oAddrErr(bErr), .oInitDone(bDone)
  );

`ifdef SPSRAM_INIT_CLEAR_EN
  localparam int ExpInitA = 10;
  localparam int ExpInitB = 20;
`else
  localparam int ExpInitA = 1;
  localparam int ExpInitB = 1;
`endif

  typedef struct {
    logic        csn;
    logic        wrn;
    logic [3:0]  addr;
    logic [15:0] wd;
    logic        vld;
    logic [15:0] dt;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  vec_t expQ[$];
  int   nTests = 0;
  int   nFail  = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic csn, input logic wrn, input logic [3:0] addr,
                              input logic [15:0] wd, input logic vld, input logic [15:0] dt,
                              input logic err);
    vec_t v;
    v.csn = csn; v.wrn = wrn; v.addr = addr; v.wd = wd;
    v.vld = vld; v.dt = dt; v.err = err;
    return v;
  endfunction

  task automatic add(input logic csn, input logic wrn, input logic [3:0] addr,
                     input logic [15:0] wd, input logic vld, input logic [15:0] dt,
                     input logic err);
    tbl.push_back(mk(csn, wrn, addr, wd, vld, dt, err));
  endtask

  // Drive one access, expect its outputs after the next rising edge.
  task automatic stepA(input vec_t v, input string name);
    vec_t e;
    aCsn = v.csn; aWrn = v.wrn; aAddr = v.addr; aWd = v.wd;
    expQ.push_back(v);
    @(posedge Clk12M); #1;
    e = expQ.pop_front();
    check(name, {30'd0, aErr, aVld, aRd}, {30'd0, e.err, e.vld, e.dt});
  endtask

  task automatic stepB(input logic csn, input logic wrn, input logic [4:0] addr,
                       input logic [23:0] wd, input logic vld, input logic [23:0] dt,
                       input logic err, input string name);
    bCsn = csn; bWrn = wrn; bAddr = addr; bWd = wd;
    @(posedge Clk12M); #1;
    check(name, {22'd0, bErr, bVld, bRd}, {22'd0, err, vld, dt});
  endtask

  task automatic doReset(input string name);
    rst = 1'b1;
    #1;
    check({name, "_a"}, {29'd0, aErr, aVld, aDone, aRd}, 48'd0);
    check({name, "_b"}, {21'd0, bErr, bVld, bDone, bRd}, 48'd0);
    aCsn = 1'b1;
    bCsn = 1'b1;
    repeat (2) @(posedge Clk12M);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitInit(input string name);
    int eA = 0;
    int eB = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge Clk12M); #1;
      if (aDone && eA == 0) eA = i;
      if (bDone && eB == 0) eB = i;
      if (eA != 0 && eB != 0) break;
    end
    check({name, "_a"}, 48'(eA), 48'(ExpInitA));
    check({name, "_b"}, 48'(eB), 48'(ExpInitB));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SPSRAM_INIT_CLEAR_EN
    for (int i = 0; i < 10; i++) add(0, 1, 4'(i), 16'h0, 1, 16'h0000, 0);
`endif
    for (int i = 0; i < 10; i++) add(0, 0, 4'(i), 16'h0A01 + 16'(i), 0, 16'h0000, 0);
    for (int i = 0; i < 10; i++) add(0, 1, 4'(i), 16'h0, 1, 16'h0A01 + 16'(i), 0);
    add(0, 0, 4'd12, 16'hBEEF, 0, 16'h0A0A, 1);
    add(0, 1, 4'd15, 16'h0,    1, 16'h0000, 1);
    for (int i = 0; i < 10; i++) add(0, 1, 4'(i), 16'h0, 1, 16'h0A01 + 16'(i), 0);
    add(0, 0, 4'd4,  16'h5555, 0, 16'h0A0A, 0);
    add(0, 1, 4'd4,  16'h0,    1, 16'h5555, 0);
    add(1, 1, 4'd4,  16'h0,    0, 16'h5555, 0);
    add(1, 0, 4'd4,  16'hFFFF, 0, 16'h5555, 0);
    add(0, 1, 4'd4,  16'h0,    1, 16'h5555, 0);
    add(0, 1, 4'd10, 16'h0,    1, 16'h0000, 1);
    add(0, 0, 4'd10, 16'h1111, 0, 16'h0000, 1);
    add(0, 1, 4'd9,  16'h0,    1, 16'h0A0A, 0);

    repeat (2) @(posedge Clk12M);
    #1;
    check("reset_a", {29'd0, aErr, aVld, aDone, aRd}, 48'd0);
    check("reset_b", {21'd0, bErr, bVld, bDone, bRd}, 48'd0);
    rst = 1'b0;
    waitInit("init_cycles");

    for (int i = 0; i < tbl.size(); i++) stepA(tbl[i], $sformatf("vec%0d", i));
    check("done_held", 48'(aDone), 48'd1);

    stepB(0, 0, 5'd19, 24'hA5A5A5, 0, 24'h000000, 0, "b_wr19");
    stepB(0, 1, 5'd19, 24'h0,      1, 24'hA5A5A5, 0, "b_rd19");
    stepB(0, 1, 5'd20, 24'h0,      1, 24'h000000, 1, "b_rd20");
    stepB(0, 1, 5'd19, 24'h0,      1, 24'hA5A5A5, 0, "b_rd19_again");
    stepB(1, 1, 5'd19, 24'h0,      0, 24'hA5A5A5, 0, "b_idle");

    // Reset lands while a read result is on the outputs.
    stepA(mk(0, 0, 4'd3, 16'h1234, 0, 16'h0A0A, 0), "wr3");
    stepA(mk(0, 1, 4'd3, 16'h0,    1, 16'h1234, 0), "rd3");
    doReset("rst_mid_access");

    repeat (5) @(posedge Clk12M);
    #1;
    check("done_mid_init", 48'(aDone), (ExpInitA > 5) ? 48'd0 : 48'd1);
    doReset("rst_mid_init");
    waitInit("reinit_cycles");

`ifdef SPSRAM_INIT_CLEAR_EN
    stepA(mk(0, 1, 4'd3, 16'h0, 1, 16'h0000, 0), "rd3_cleared");
`else
    stepA(mk(0, 0, 4'd3, 16'h7777, 0, 16'h0000, 0), "wr3_post");
    stepA(mk(0, 1, 4'd3, 16'h0,    1, 16'h7777, 0), "rd3_post");
`endif
    stepA(mk(1, 1, 4'd3, 16'h0, 0, aRd, 0), "idle_hold");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/sp_sram_param.md
SP_SRAM_PARAM -- requirements
Module: sp_sram_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16: word width in bits.
REQ-002 SHALL have parameter DEPTH, default 10: number of words, from 2 to 2**ADDR_W.
REQ-003 SHALL have parameter ADDR_W, default 4: address width in bits.
REQ-004 SHALL have port iClk12M, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-005 SHALL have port iRst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port iCsnRam, input, 1 bit: chip select, active-low.
REQ-007 SHALL have port iWrnRam, input, 1 bit: 0 selects write, 1 selects read; only meaningful while iCsnRam=0.
REQ-008 SHALL have port iAddrRam, input, ADDR_W bits: word address.
REQ-009 SHALL have port iWtDtRam, input, DATA_W bits: write data.
REQ-010 SHALL have port oRdDtRam, output, DATA_W bits: registered read data.
REQ-011 SHALL have port oRdVld, output, 1 bit: one-cycle pulse marking new oRdDtRam.
REQ-012 SHALL have port oAddrErr, output, 1 bit: one-cycle pulse on an access with iAddrRam >= DEPTH.
REQ-013 SHALL have port oInitDone, output, 1 bit: high when the block accepts accesses.

Function
REQ-014 SHALL implement a two-state FSM.
  - INIT: clears memory, ignores all accesses.
  - READY: serves accesses.
  - INIT -> READY when the sweep completes; READY has no exit except reset.
REQ-015 INIT SHALL write zero to one address per cycle, in order 0..DEPTH-1, using an internal counter; DEPTH cycles in total.
REQ-016 oInitDone SHALL go to 1 in the cycle after address DEPTH-1 is cleared and stay at 1 until reset.
REQ-017 A write SHALL occur in READY when, at a rising edge, iCsnRam=0, iWrnRam=0 and iAddrRam<DEPTH: mem[iAddrRam] <= iWtDtRam.
REQ-018 A read SHALL occur in READY when, at a rising edge, iCsnRam=0, iWrnRam=1 and iAddrRam<DEPTH.
  - oRdDtRam <= mem[iAddrRam] with 1-cycle latency.
  - oRdVld=1 for exactly that following cycle.
REQ-019 Back-to-back reads SHALL give one result per cycle, with oRdVld held high continuously.
REQ-020 A write SHALL leave oRdDtRam unchanged and keep oRdVld=0.
REQ-021 A write immediately followed by a read of the same address SHALL return the newly written data.
REQ-022 An access in READY with iAddrRam >= DEPTH SHALL not modify memory.
  - Out-of-range read: oRdDtRam <= 0 and oRdVld pulses.
  - Read or write: oAddrErr pulses 1 cycle.
REQ-023 With iCsnRam=1, or in INIT, oRdDtRam SHALL hold its value and oRdVld and oAddrErr SHALL be 0.
REQ-024 The INIT counter SHALL stop at DEPTH-1 and never wrap; it SHALL support non-power-of-2 DEPTH.

Reset
REQ-025 Asserting iRst SHALL immediately force oRdDtRam=0, oRdVld=0, oAddrErr=0, oInitDone=0, FSM=INIT and counter=0.
REQ-026 Reset asserted mid-INIT or mid-access SHALL abort the operation; the sweep SHALL restart from address 0 on the first rising edge after iRst falls.
REQ-027 Memory contents SHALL not be reset asynchronously; clearing happens only through the INIT sweep.

Configuration
REQ-028 Macro SPSRAM_INIT_CLEAR_EN SHALL control the INIT sweep.
  - Defined: INIT sweep as in REQ-015/016.
  - Undefined: no sweep and no counter; FSM enters READY at the first rising edge after reset release; oInitDone=1 from that cycle; memory contents undefined until written.

Verification
REQ-029 Defaults; reset pulse; check the sweep -> oInitDone=0 for 10 cycles after release, then 1; reading addresses 0..9 returns 16'h0000.
REQ-030 Write 16'h0A01..16'h0A0A to addresses 0..9, then read 0..9 back-to-back -> oRdDtRam = 16'h0A01..16'h0A0A, one per cycle, 1-cycle latency, oRdVld high for 10 consecutive cycles.
REQ-031 Write 16'hBEEF to address 12, then read address 15 -> memory unchanged, oAddrErr pulses once per access, read returns 16'h0000 with oRdVld=1.
REQ-032 Assert iRst at cycle 5 of INIT after 16'h1234 was previously written to address 3 -> all outputs 0 at once, sweep restarts at 0, address 3 reads 16'h0000 after oInitDone.
REQ-033 Write 16'h5555 to address 4, then read address 4 on the next cycle -> 16'h5555 with oRdVld=1.
REQ-034 DATA_W=24, DEPTH=20, ADDR_W=5, with and without SPSRAM_INIT_CLEAR_EN: write 24'hA5A5A5 to address 19 -> reads back 24'hA5A5A5; oInitDone timing is 20 cycles with the macro and 1 cycle without.
